// File: rtl/fp_i2f_arbiter.sv
// Shares one integer-to-float converter among NUM_REQ requesters (grant -> convert -> respond).
// Define FP_I2F_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
package fp_i2f_arbiter_pkg;

    typedef enum logic [1:0] {INT8, INT16, INT32} int_format_e;
    typedef enum logic [1:0] {FP16, BF16, FP32} fp_format_e;

    localparam int unsigned URES_W = 32;

    // Converter result before rounding: truncated value plus round/sticky bits
    typedef struct packed {
        logic [URES_W-1:0] u_result;
        logic              round_bit;
        logic              sticky_bit;
    } uround_res_t;

    function automatic int unsigned int_width(int_format_e fmt);
        case (fmt)
            INT8:    return 8;
            INT16:   return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP16, BF16: return 16;
            default:    return 32;
        endcase
    endfunction

endpackage

module fp_i2f_arbiter
    import fp_i2f_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int_format_e INT_FORMAT = INT32,
    parameter fp_format_e  FP_FORMAT  = FP32,
    localparam int unsigned INT_WIDTH = int_width(INT_FORMAT),
    localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_signed_i,
    input  logic [NUM_REQ*INT_WIDTH-1:0] req_a_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         cvt_start_o,
    output logic [INT_WIDTH-1:0]         cvt_a_o,
    output logic                         cvt_signed_o,
    input  logic                         cvt_done_i,
    input  uround_res_t                  cvt_result_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [IDX_W-1:0]             rsp_id_o,
    output uround_res_t                  rsp_result_o
);

    // Narrow float formats live in the low bits of u_result
    localparam int unsigned       FP_WIDTH = fp_width(FP_FORMAT);
    localparam logic [URES_W-1:0] RES_MASK = URES_W'((64'd1 << FP_WIDTH) - 64'd1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                 state_q, state_d;
    logic                   cvt_start_q, cvt_start_d;
    logic [INT_WIDTH-1:0]   cvt_a_q, cvt_a_d;
    logic                   cvt_signed_q, cvt_signed_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]       rsp_id_q, rsp_id_d;
    uround_res_t            rsp_result_q, rsp_result_d;

    logic                   gnt_valid;
    logic [IDX_W-1:0]       gnt_idx;
    logic [INT_WIDTH-1:0]   req_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_a[g] = req_a_i[g*INT_WIDTH +: INT_WIDTH];
    end

`ifdef FP_I2F_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // First valid requester at or above the pointer, wrapping
    always_comb begin
        int unsigned cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr_q) + off) % NUM_REQ;
            if (!gnt_valid && req_valid_i[IDX_W'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end
`else
    // Lowest valid index wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_valid && req_valid_i[IDX_W'(k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        req_ready_o = '0;
        if (rst_ni && state_q == IDLE && gnt_valid) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cvt_start_d  = cvt_start_q;
        cvt_a_d      = cvt_a_q;
        cvt_signed_d = cvt_signed_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
`ifdef FP_I2F_ARB_RR_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d      = BUSY;
                    cvt_start_d  = 1'b1;
                    cvt_a_d      = req_a[gnt_idx];
                    cvt_signed_d = req_signed_i[gnt_idx];
                    rsp_id_d     = gnt_idx;
`ifdef FP_I2F_ARB_RR_EN
                    ptr_d        = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
                end
            end
            BUSY: begin
                if (cvt_done_i) begin
                    state_d               = RESP;
                    cvt_start_d           = 1'b0;
                    rsp_valid_d           = 1'b1;
                    rsp_result_d          = cvt_result_i;
                    rsp_result_d.u_result = cvt_result_i.u_result & RES_MASK;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cvt_start_q  <= 1'b0;
            cvt_a_q      <= '0;
            cvt_signed_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
`ifdef FP_I2F_ARB_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cvt_start_q  <= cvt_start_d;
            cvt_a_q      <= cvt_a_d;
            cvt_signed_q <= cvt_signed_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
`ifdef FP_I2F_ARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign cvt_start_o  = cvt_start_q;
    assign cvt_a_o      = cvt_a_q;
    assign cvt_signed_o = cvt_signed_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;

endmodule

// File: tb/tb_fp_i2f_arbiter.sv
// Bench for fp_i2f_arbiter: the bench acts as requesters, converter and response consumer,
// and predicts grants and results from an arbitration model and an int-to-float reference.
module tb_fp_i2f_arbiter;
    import fp_i2f_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   pend;
    logic [3:0]   sgn;
    logic [31:0]  a_m [4];
    logic [127:0] req_a;
    logic [3:0]   req_ready;
    logic         cvt_start;
    logic [31:0]  cvt_a;
    logic         cvt_sgn;
    logic         cvt_done;
    uround_res_t  cvt_res;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    uround_res_t  rsp_result;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_gcyc = 0;
`ifdef FP_I2F_ARB_RR_EN
    int ptr_m = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req_a = {a_m[3], a_m[2], a_m[1], a_m[0]};

    fp_i2f_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (pend),
        .req_signed_i (sgn),
        .req_a_i      (req_a),
        .req_ready_o  (req_ready),
        .cvt_start_o  (cvt_start),
        .cvt_a_o      (cvt_a),
        .cvt_signed_o (cvt_sgn),
        .cvt_done_i   (cvt_done),
        .cvt_result_i (cvt_res),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result)
    );

    // Truncating int -> FP32 conversion with round and sticky bits
    function automatic logic [33:0] ref_i2f(input logic [31:0] a, input logic s);
        logic        neg;
        logic [31:0] mag;
        logic [31:0] man;
        logic        r;
        logic        st;
        int          msb;
        neg = s && a[31];
        mag = neg ? (32'd0 - a) : a;
        if (mag == 32'd0) return 34'd0;
        msb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
        r  = 1'b0;
        st = 1'b0;
        if (msb <= 23) begin
            man = mag << (23 - msb);
        end else begin
            man = mag >> (msb - 23);
            r   = mag[msb - 24];
            if (msb > 24) st = |(mag & ((32'd1 << (msb - 24)) - 32'd1));
        end
        return {neg, 8'(127 + msb), man[22:0], r, st};
    endfunction

    // Converter stand-in: real result only while done is high, junk otherwise
    always_comb cvt_res = cvt_done ? uround_res_t'(ref_i2f(cvt_a, cvt_sgn))
                                   : uround_res_t'(34'h2_5A5A_5A5A);

    function automatic int winner(input logic [3:0] v);
`ifdef FP_I2F_ARB_RR_EN
        for (int o = 0; o < 4; o++) begin
            if (v[2'((ptr_m + o) % 4)]) return (ptr_m + o) % 4;
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (v[2'(i)]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  64'(req_ready), 64'd0);
        check({tag, "_start"},  64'(cvt_start), 64'd0);
        check({tag, "_cvt_a"},  64'(cvt_a), 64'd0);
        check({tag, "_cvt_s"},  64'(cvt_sgn), 64'd0);
        check({tag, "_rsp_v"},  64'(rsp_valid), 64'd0);
        check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        check({tag, "_rsp_r"},  64'(rsp_result), 64'd0);
    endtask

    // One full grant/convert/respond transaction, entered and left in an IDLE cycle
    task automatic run_txn(input int done_dly, input int bp, input bit keep,
                           input bit use_u, input logic [31:0] exp_u, input bit chk_tp);
        int          w;
        int          gcyc;
        logic [33:0] er;
        #1;
        w = winner(pend);
        if (w < 0) w = 0;
        check("grant", 64'(req_ready), 64'(4'b0001 << w));
        er   = ref_i2f(a_m[w], sgn[w]);
        gcyc = cyc;
        if (chk_tp) check("throughput", 64'(gcyc - last_gcyc), 64'd3);
        last_gcyc = gcyc;
        tick();
`ifdef FP_I2F_ARB_RR_EN
        ptr_m = (w + 1) % 4;
`endif
        if (!keep) pend[w] = 1'b0;
        #1;
        check("busy_ready", 64'(req_ready), 64'd0);
        for (int k = 0; k < done_dly; k++) begin
            check("busy_start", 64'(cvt_start), 64'd1);
            check("busy_a", 64'(cvt_a), 64'(a_m[w]));
            check("busy_rsp_valid", 64'(rsp_valid), 64'd0);
            tick();
        end
        check("start", 64'(cvt_start), 64'd1);
        check("cvt_a", 64'(cvt_a), 64'(a_m[w]));
        check("cvt_signed", 64'(cvt_sgn), 64'(sgn[w]));
        cvt_done = 1'b1;
        tick();
        cvt_done = 1'b0;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(w));
        check("rsp_result", 64'(rsp_result), 64'(er));
        check("latency", 64'(cyc - gcyc), 64'(2 + done_dly));
        check("resp_start", 64'(cvt_start), 64'd0);
        if (use_u) check("rsp_u_result", 64'(rsp_result.u_result), 64'(exp_u));
        rsp_ready = 1'b0;
        for (int k = 0; k < bp; k++) begin
            tick();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id", 64'(rsp_id), 64'(w));
            check("bp_result", 64'(rsp_result), 64'(er));
            check("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("rsp_release", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        pend      = 4'b0000;
        sgn       = 4'b0000;
        cvt_done  = 1'b0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) a_m[k] = 32'd0;
        tick();
        tick();
        check_all_zero("reset");
        pend = 4'b1111;
        #1;
        check("reset_ready_gated", 64'(req_ready), 64'd0);
        pend = 4'b0000;
        rst_n = 1'b1;
        tick();

        // Single request, then a signed one on requester 2
        a_m[0] = 32'd1; sgn[0] = 1'b0; pend = 4'b0001;
        run_txn(0, 0, 0, 1, 32'h3F80_0000, 0);
        a_m[2] = 32'hFFFF_FFFF; sgn[2] = 1'b1; pend = 4'b0100;
        run_txn(0, 0, 0, 1, 32'hBF80_0000, 0);

        // Zero operand passes through untouched
        a_m[1] = 32'd0; sgn[1] = 1'b1; pend = 4'b0010;
        run_txn(1, 0, 0, 1, 32'd0, 0);

        // Converter slow to finish, then long response backpressure
        a_m[3] = 32'd1000; sgn[3] = 1'b0; pend = 4'b1000;
        run_txn(3, 0, 0, 0, 32'd0, 0);
        a_m[1] = 32'hFFFF_FFFB; sgn[1] = 1'b1; pend = 4'b0010;
        run_txn(0, 5, 0, 0, 32'd0, 0);

        // All requesters held valid back to back
        for (int k = 0; k < 4; k++) begin
            a_m[k] = $urandom;
            sgn[k] = 1'($urandom_range(0, 1));
        end
        pend = 4'b1111;
        for (int i = 0; i < 5; i++) run_txn(0, 0, 1, 0, 32'd0, i > 0);
        pend = 4'b0000;

        // Reset while a conversion is in flight
        a_m[1] = 32'h1234_5678; sgn[1] = 1'b1;
        a_m[3] = 32'hDEAD_BEEF; sgn[3] = 1'b1;
        pend = 4'b1010;
        #1;
        check("pre_rst_grant", 64'(req_ready), 64'(4'b0001 << winner(pend)));
        tick();
        check("pre_rst_start", 64'(cvt_start), 64'd1);
        rst_n = 1'b0;
`ifdef FP_I2F_ARB_RR_EN
        ptr_m = 0;
`endif
        #1;
        check_all_zero("midrst");
        tick();
        check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        run_txn(1, 0, 0, 0, 32'd0, 0);
        pend = 4'b0000;

        // Random traffic; pending requests keep their operand until served
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < 4; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    a_m[k]  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                    sgn[k]  = 1'($urandom_range(0, 1));
                end
            end
            if (pend == 4'b0000) begin
                pend[0] = 1'b1;
                a_m[0]  = $urandom;
                sgn[0]  = 1'($urandom_range(0, 1));
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 2), 0, 0, 32'd0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
